axi4_mem_fill: RTL and testbench

AXI4 write-only master that fills a memory region with a constant or incrementing data pattern, issued as INCR bursts. It sits directly upstream of the AXI4 SRAM slave and drives its `axi4_if` slave port. Typical uses are clearing SRAM after reset and preloading test patterns before a read-back check. One burst is in flight at a time, and the fill is split so that no burst crosses a 4 KB boundary.

---
 rtl/axi4_mem_fill_if.sv | 70 +++++++
 rtl/axi4_mem_fill.sv | 126 ++++++++++++
 tb/tb_axi4_mem_fill.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/axi4_mem_fill_if.sv
// axi4_if: AXI4 bus bundle between the fill master and the SRAM slave.
interface axi4_if #(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ID_WIDTH      = 4
);
  logic [AXI_ID_WIDTH-1:0]       awid;
  logic [AXI_ADDRESS_WIDTH-1:0]  awaddr;
  logic [7:0]                    awlen;
  logic [2:0]                    awsize;
  logic [1:0]                    awburst;
  logic                          awlock;
  logic [3:0]                    awcache;
  logic [2:0]                    awprot;
  logic [3:0]                    awqos;
  logic [3:0]                    awregion;
  logic                          awvalid;
  logic                          awready;
  logic [AXI_DATA_WIDTH-1:0]     wdata;
  logic [AXI_DATA_WIDTH/8-1:0]   wstrb;
  logic                          wlast;
  logic                          wvalid;
  logic                          wready;
  logic [AXI_ID_WIDTH-1:0]       bid;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;
  logic [AXI_ID_WIDTH-1:0]       arid;
  logic [AXI_ADDRESS_WIDTH-1:0]  araddr;
  logic [7:0]                    arlen;
  logic [2:0]                    arsize;
  logic [1:0]                    arburst;
  logic                          arlock;
  logic [3:0]                    arcache;
  logic [2:0]                    arprot;
  logic [3:0]                    arqos;
  logic [3:0]                    arregion;
  logic                          arvalid;
  logic                          arready;
  logic [AXI_ID_WIDTH-1:0]       rid;
  logic [AXI_DATA_WIDTH-1:0]     rdata;
  logic [1:0]                    rresp;
  logic                          rlast;
  logic                          rvalid;
  logic                          rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_mem_fill.sv
// axi4_mem_fill: AXI4 write master filling a region with constant/incrementing data in 4KB-safe INCR bursts.
module axi4_mem_fill #(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ID_WIDTH      = 4,
  parameter int MAX_BURST         = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         start,
  input  logic [AXI_ADDRESS_WIDTH-1:0] base_addr,
  input  logic [15:0]                  num_beats,
  input  logic [AXI_DATA_WIDTH-1:0]    pattern,
  input  logic                         incr_en,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  axi4_if.master                       m
);
  localparam int SZ = $clog2(AXI_DATA_WIDTH/8);
  localparam logic [AXI_ADDRESS_WIDTH-1:0] AMASK =
    ~((AXI_ADDRESS_WIDTH'(1) << SZ) - AXI_ADDRESS_WIDTH'(1));
  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;
  state_t                        state_q, state_d;
  logic [AXI_ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic [15:0]                   rem_q, rem_d;
  logic [8:0]                    beat_q, beat_d;
  logic [AXI_DATA_WIDTH-1:0]     data_q, data_d;
  logic                          incr_q, incr_d;
  logic                          err_q, err_d;
  logic [12:0]                   bnd;
  logic [15:0]                   lim;
  logic [8:0]                    len_c;
  logic                          unused;
  // addr_q/rem_q only move in B, so the burst length stays valid across AW, W and B
  assign bnd   = (13'd4096 - {1'b0, addr_q[11:0]}) >> SZ;
  assign lim   = (rem_q < 16'(MAX_BURST)) ? rem_q : 16'(MAX_BURST);
  assign len_c = (16'(bnd) < lim) ? 9'(bnd) : 9'(lim);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    data_d  = data_q;
    incr_d  = incr_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        addr_d  = base_addr & AMASK;
        rem_d   = num_beats;
        data_d  = pattern;
        incr_d  = incr_en;
        err_d   = 1'b0;
        beat_d  = '0;
        state_d = (num_beats == 16'd0) ? S_DONE : S_AW;
      end
      S_AW: if (m.awready) begin
        beat_d  = '0;
        state_d = S_W;
      end
      S_W: if (m.wready) begin
        beat_d  = beat_q + 9'd1;
        data_d  = incr_q ? data_q + AXI_DATA_WIDTH'(1) : data_q;
        state_d = m.wlast ? S_B : S_W;
      end
      S_B: if (m.bvalid) begin
        addr_d  = addr_q + (AXI_ADDRESS_WIDTH'(len_c) << SZ);
        rem_d   = rem_q - 16'(len_c);
        err_d   = err_q | (m.bresp != 2'b00);
        state_d = (m.bresp != 2'b00 || rem_d == 16'd0) ? S_DONE : S_AW;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      data_q  <= '0;
      incr_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      incr_q  <= incr_d;
      err_q   <= err_d;
    end
  end
  assign busy       = (state_q == S_AW) || (state_q == S_W) || (state_q == S_B);
  assign done       = (state_q == S_DONE);
  assign error      = err_q;
  assign m.awid     = '0;
  assign m.awaddr   = addr_q;
  assign m.awlen    = 8'(len_c - 9'd1);
  assign m.awsize   = 3'(SZ);
  assign m.awburst  = 2'b01;
  assign m.awlock   = 1'b0;
  assign m.awcache  = '0;
  assign m.awprot   = '0;
  assign m.awqos    = '0;
  assign m.awregion = '0;
  assign m.awvalid  = (state_q == S_AW);
  assign m.wdata    = data_q;
  assign m.wstrb    = '1;
  assign m.wlast    = (state_q == S_W) && (beat_q == len_c - 9'd1);
  assign m.wvalid   = (state_q == S_W);
  assign m.bready   = (state_q == S_B);
  assign m.arid     = '0;
  assign m.araddr   = '0;
  assign m.arlen    = '0;
  assign m.arsize   = '0;
  assign m.arburst  = '0;
  assign m.arlock   = 1'b0;
  assign m.arcache  = '0;
  assign m.arprot   = '0;
  assign m.arqos    = '0;
  assign m.arregion = '0;
  assign m.arvalid  = 1'b0;
  assign m.rready   = 1'b1;
  assign unused = ^{m.bid, m.arready, m.rid, m.rdata, m.rresp, m.rlast, m.rvalid};
endmodule

// File: tb/tb_axi4_mem_fill.sv
// tb_axi4_mem_fill: directed fill scenarios against a behavioural AXI4 SRAM slave.
module tb_axi4_mem_fill;
  logic        ACLK = 1'b0, ARESET = 1'b1, start = 1'b0, incr_en = 1'b0;
  logic [31:0] base_addr = '0, pattern = '0;
  logic [15:0] num_beats = '0;
  logic        busy, done, error;
  int          n_chk = 0, n_pass = 0;
  logic [31:0] mem [0:2047];
  logic [31:0] snap [0:2047];
  logic [31:0] cur;
  logic [7:0]  cur_len;
  int          beat;
  logic        bp = 1'b0, err_mode = 1'b0, mem_clr = 1'b0;
  logic        pa, pw;
  logic [44:0] pav;
  logic [32:0] pwv;
  logic [31:0] aw_addr_q [$];
  logic [7:0]  aw_len_q [$];
  logic [31:0] wd_q [$];
  int          viol = 0, done_cnt = 0;
  axi4_if #(.AXI_ADDRESS_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4)) m_if ();
  axi4_mem_fill #(.AXI_ADDRESS_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4), .MAX_BURST(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .base_addr(base_addr), .num_beats(num_beats),
    .pattern(pattern), .incr_en(incr_en), .busy(busy), .done(done), .error(error), .m(m_if)
  );
  always #5 ACLK = ~ACLK;
  initial begin
    m_if.bid = '0; m_if.arready = 1'b0; m_if.rid = '0; m_if.rdata = '0;
    m_if.rresp = '0; m_if.rlast = 1'b0; m_if.rvalid = 1'b0;
  end
  always @(posedge ACLK) begin
    if (ARESET || mem_clr)
      for (int i = 0; i < 2048; i++) mem[i] <= '0;
    if (ARESET) begin
      m_if.awready <= 1'b0; m_if.wready <= 1'b0; m_if.bvalid <= 1'b0; m_if.bresp <= '0;
      pa <= 1'b0; pw <= 1'b0;
    end else begin
      m_if.awready <= bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      m_if.wready  <= bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (pa && pav != {m_if.awaddr, m_if.awlen, m_if.awsize, m_if.awburst}) viol++;
      if (pw && pwv != {m_if.wdata, m_if.wlast}) viol++;
      pa  <= m_if.awvalid && !m_if.awready;
      pav <= {m_if.awaddr, m_if.awlen, m_if.awsize, m_if.awburst};
      pw  <= m_if.wvalid && !m_if.wready;
      pwv <= {m_if.wdata, m_if.wlast};
      if (m_if.awvalid && m_if.wvalid) viol++;
      if (m_if.awvalid && m_if.awready) begin
        cur <= m_if.awaddr; cur_len <= m_if.awlen; beat <= 0;
        aw_addr_q.push_back(m_if.awaddr); aw_len_q.push_back(m_if.awlen);
      end
      if (m_if.wvalid && m_if.wready) begin
        mem[cur[12:2]] <= m_if.wdata;
        cur <= cur + 32'd4;
        beat <= beat + 1;
        wd_q.push_back(m_if.wdata);
        if (m_if.wlast != (beat == int'(cur_len))) viol++;
        if (m_if.wlast) begin
          m_if.bvalid <= 1'b1;
          m_if.bresp  <= err_mode ? 2'b10 : 2'b00;
        end
      end
      if (m_if.bvalid && m_if.bready) m_if.bvalid <= 1'b0;
      if (done) done_cnt++;
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic fill(input logic [31:0] b, input logic [15:0] n, input logic [31:0] p, input logic inc,
                      output int lat, output logic b1, output logic bd);
    aw_addr_q.delete(); aw_len_q.delete(); wd_q.delete(); done_cnt = 0;
    @(negedge ACLK);
    base_addr = b; num_beats = n; pattern = p; incr_en = inc; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0; b1 = busy; lat = 1;
    while (!done && lat < 3000) begin
      @(negedge ACLK);
      lat++;
    end
    if (!done) chk("timeout", 0, 1);
    bd = busy;
    repeat (3) @(negedge ACLK);
  endtask
  task automatic clr_mem();
    @(negedge ACLK); mem_clr = 1'b1;
    @(negedge ACLK); mem_clr = 1'b0;
  endtask
  initial begin
    int lat, diff, k;
    logic b1, bd, wseen;
    repeat (3) @(negedge ACLK);
    chk("reset", {busy, done, error, m_if.awvalid, m_if.wvalid, m_if.wlast, m_if.bready}, 0);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    fill(32'h100, 16'd4, 32'hA5A5_0000, 1'b1, lat, b1, bd);
    chk("t1_busy_n1", {b1, bd}, 2'b10);
    chk("t1_aw_cnt", aw_addr_q.size(), 1);
    chk("t1_aw", {aw_addr_q[0], aw_len_q[0]}, {32'h100, 8'd3});
    chk("t1_w_cnt", wd_q.size(), 4);
    for (k = 0; k < 4; k++) begin
      chk("t1_wdata", wd_q[k], 32'hA5A5_0000 + k);
      chk("t1_mem", mem[32'h40 + k], 32'hA5A5_0000 + k);
    end
    chk("t1_done_err", {done_cnt[3:0], error}, {4'd1, 1'b0});
    fill(32'h0, 16'd40, 32'h0, 1'b1, lat, b1, bd);
    chk("t2_aw_cnt", aw_addr_q.size(), 3);
    chk("t2_aw0", {aw_addr_q[0], aw_len_q[0]}, {32'h000, 8'd15});
    chk("t2_aw1", {aw_addr_q[1], aw_len_q[1]}, {32'h040, 8'd15});
    chk("t2_aw2", {aw_addr_q[2], aw_len_q[2]}, {32'h080, 8'd7});
    chk("t2_mem_last", mem[39], 32'd39);
    fill(32'hFF8, 16'd8, 32'h1000, 1'b0, lat, b1, bd);
    chk("t3_aw_cnt", aw_addr_q.size(), 2);
    chk("t3_aw0", {aw_addr_q[0], aw_len_q[0]}, {32'hFF8, 8'd1});
    chk("t3_aw1", {aw_addr_q[1], aw_len_q[1]}, {32'h1000, 8'd5});
    chk("t3_mem_hi", mem[32'h405], 32'h1000);
    fill(32'h203, 16'd1, 32'hDEAD_BEEF, 1'b1, lat, b1, bd);
    chk("align_aw", {aw_addr_q[0], aw_len_q[0]}, {32'h200, 8'd0});
    chk("align_mem", mem[32'h80], 32'hDEAD_BEEF);
    clr_mem();
    fill(32'h0, 16'd40, 32'h5000, 1'b1, lat, b1, bd);
    for (int i = 0; i < 2048; i++) snap[i] = mem[i];
    clr_mem();
    bp = 1'b1;
    fill(32'h0, 16'd40, 32'h5000, 1'b1, lat, b1, bd);
    bp = 1'b0;
    diff = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== snap[i]) diff++;
    chk("bp_mem_diff", diff, 0);
    chk("bp_mem_last", mem[39], 32'h5027);
    chk("bp_aw_cnt", aw_addr_q.size(), 3);
    err_mode = 1'b1;
    fill(32'h400, 16'd40, 32'h1, 1'b1, lat, b1, bd);
    err_mode = 1'b0;
    chk("err_aw_cnt", aw_addr_q.size(), 1);
    chk("err_sticky", error, 1);
    chk("err_done", done_cnt, 1);
    fill(32'h400, 16'd2, 32'h1, 1'b1, lat, b1, bd);
    chk("err_cleared", error, 0);
    fill(32'h600, 16'd0, 32'h9, 1'b1, lat, b1, bd);
    chk("zero_lat", lat <= 2, 1);
    chk("zero_aw", aw_addr_q.size(), 0);
    chk("zero_done", {done_cnt[3:0], b1, bd}, {4'd1, 2'b00});
    aw_addr_q.delete(); aw_len_q.delete(); wd_q.delete();
    @(negedge ACLK);
    base_addr = 32'h0; num_beats = 16'd40; pattern = 32'h0; incr_en = 1'b1; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    wseen = 1'b0;
    for (k = 0; k < 50 && !wseen; k++) begin
      @(negedge ACLK);
      wseen = m_if.wvalid;
    end
    chk("rst_w_seen", wseen, 1);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("rst_mid", {busy, done, error, m_if.awvalid, m_if.wvalid, m_if.wlast, m_if.bready}, 0);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    fill(32'h300, 16'd5, 32'h77, 1'b1, lat, b1, bd);
    chk("rst_new_aw", {aw_addr_q.size() == 1, aw_addr_q[0], aw_len_q[0]}, {1'b1, 32'h300, 8'd4});
    chk("rst_new_mem", mem[32'hC4], 32'h7B);
    chk("rst_new_done", done_cnt, 1);
    chk("protocol_viol", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
